// File: rtl/stage_m_pkg.sv
// rtl/stage_m_pkg.sv - opcodes, exception vector, FSM states and memory-op helpers for the M stage
package stage_m_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    function automatic logic is_load(input logic [5:0] op);
        return op[5:3] == 3'd4;
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op[5:3] == 3'd5;
    endfunction

    // Undefined encodings inside the load/store groups are treated as word accesses.
    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LW, OP_SW:         return SZ_WORD;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    // Big-endian lanes: offset 0 lives in [31:24], i.e. strobe bit 3.
    function automatic logic [3:0] store_wbe(input logic [5:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_BYTE: return 4'b1000 >> off;
            SZ_HALF: return off[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [5:0] op, input logic [31:0] rt);
        case (op_size(op))
            SZ_BYTE: return {4{rt[7:0]}};
            SZ_HALF: return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

endpackage

// File: rtl/stage_m_load_align.sv
// rtl/stage_m_load_align.sv - big-endian byte/halfword extraction and extension of load data
module load_align
    import stage_m_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [5:0]  opcode,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[15:0] : rdata[31:16];
        sign     = 1'b0;
        result   = rdata;
        case (op_size(opcode))
            SZ_BYTE: begin
                sign   = is_signed_load(opcode) && byte_sel[7];
                result = {{24{sign}}, byte_sel};
            end
            SZ_HALF: begin
                sign   = is_signed_load(opcode) && half_sel[15];
                result = {{16{sign}}, half_sel};
            end
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/stage_m.sv
// rtl/stage_m.sv - memory pipeline stage: load/store issue, busy handshake, response alignment
module stage_m
    import stage_m_pkg::*;
#(
    parameter int debug = 0
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        x_valid,
    input  logic [31:0] x_instr,
    input  logic [31:0] x_pc,
    input  logic [5:0]  x_opcode,
    input  logic [31:0] x_op1_val,
    input  logic [31:0] x_rt_val,
    input  logic [5:0]  x_wbr,
    input  logic [31:0] x_res,
    input  logic        x_restart,
    input  logic [31:0] x_restart_pc,
    output logic [31:0] dmem_addr,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wbe,
    input  logic        dmem_busy,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_rdata_valid,
    output logic        m_valid,
    output logic [31:0] m_pc,
    output logic [5:0]  m_wbr,
    output logic [31:0] m_res,
    output logic        m_stall,
    output logic        m_restart,
    output logic [31:0] m_restart_pc
);

    state_t      state;
    logic [31:0] ea;
    logic        x_load;
    logic        x_store;
    logic        x_mem;
    logic        x_mis;
    logic        issue;
    logic        in_req;
    logic [31:0] load_result;
    logic        unused_instr_hi;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wbe;
    logic        req_load;
    logic [1:0]  req_off;
    logic [5:0]  req_opcode;
    logic [31:0] req_pc;
    logic [5:0]  req_wbr;

    assign ea              = x_op1_val + {{16{x_instr[15]}}, x_instr[15:0]};
    assign unused_instr_hi = ^x_instr[31:16];
    assign x_load          = x_valid && is_load(x_opcode);
    assign x_store         = x_valid && is_store(x_opcode);
    assign x_mem           = x_load || x_store;
    assign x_mis           = x_mem && misaligned(x_opcode, ea[1:0]);
    assign issue           = (state == S_IDLE) && x_mem && !x_mis;
    assign in_req          = (state == S_REQ);

    // Stall only while a request is refused or a load response is outstanding,
    // so an accepted access lets EX advance in the same cycle.
    assign m_stall = !reset && ((state == S_WAIT) || ((issue || in_req) && dmem_busy));

    always_comb begin
        dmem_addr  = '0;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        dmem_wdata = '0;
        dmem_wbe   = '0;
        if (!reset) begin
            if (in_req) begin
                dmem_addr  = req_addr;
                dmem_rd    = req_load;
                dmem_wr    = !req_load;
                dmem_wdata = req_wdata;
                dmem_wbe   = req_wbe;
            end else if (issue) begin
                dmem_addr  = {ea[31:2], 2'b00};
                dmem_rd    = x_load;
                dmem_wr    = x_store;
                dmem_wdata = x_store ? store_wdata(x_opcode, x_rt_val) : '0;
                dmem_wbe   = x_store ? store_wbe(x_opcode, ea[1:0]) : 4'b0000;
            end
        end
    end

    load_align u_align (
        .addr   (req_off),
        .opcode (req_opcode),
        .rdata  (dmem_rdata),
        .result (load_result)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            m_valid      <= 1'b0;
            m_pc         <= '0;
            m_wbr        <= '0;
            m_res        <= '0;
            m_restart    <= 1'b0;
            m_restart_pc <= '0;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_wbe      <= '0;
            req_load     <= 1'b0;
            req_off      <= '0;
            req_opcode   <= '0;
            req_pc       <= '0;
            req_wbr      <= '0;
        end else begin
            m_valid   <= 1'b0;
            m_restart <= 1'b0;
            case (state)
                S_IDLE: begin
                    m_restart    <= x_restart;
                    m_restart_pc <= x_restart_pc;
                    if (x_mis) begin
                        m_restart    <= 1'b1;
                        m_restart_pc <= EXC_VECTOR;
                    end else if (issue) begin
                        req_addr   <= {ea[31:2], 2'b00};
                        req_wdata  <= store_wdata(x_opcode, x_rt_val);
                        req_wbe    <= x_store ? store_wbe(x_opcode, ea[1:0]) : 4'b0000;
                        req_load   <= x_load;
                        req_off    <= ea[1:0];
                        req_opcode <= x_opcode;
                        req_pc     <= x_pc;
                        req_wbr    <= x_wbr;
                        if (dmem_busy) begin
                            state <= S_REQ;
                        end else if (x_load) begin
                            state <= S_WAIT;
                        end else begin
                            m_valid <= 1'b1;
                            m_pc    <= x_pc;
                            m_wbr   <= '0;
                            m_res   <= '0;
                        end
                    end else if (!x_mem) begin
                        m_valid <= x_valid;
                        m_pc    <= x_pc;
                        m_wbr   <= x_wbr;
                        m_res   <= x_res;
                    end
                end
                S_REQ: begin
                    if (!dmem_busy) begin
                        if (req_load) begin
                            state <= S_WAIT;
                        end else begin
                            state   <= S_IDLE;
                            m_valid <= 1'b1;
                            m_pc    <= req_pc;
                            m_wbr   <= '0;
                            m_res   <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rdata_valid) begin
                        state   <= S_IDLE;
                        m_valid <= 1'b1;
                        m_pc    <= req_pc;
                        m_wbr   <= req_wbr;
                        m_res   <= load_result;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    generate
        if (debug != 0) begin : g_debug
            always_ff @(posedge clock) begin
                if (!reset) begin
                    assert (state == S_IDLE || !m_valid);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_stage_m.sv
// tb/tb_stage_m.sv - directed and randomized bench for stage_m against a byte-level memory model
module tb_stage_m;

    localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
    localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, ADDU = 6'h00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        x_valid = 1'b0;
    logic [31:0] x_instr = '0;
    logic [31:0] x_pc = '0;
    logic [5:0]  x_opcode = '0;
    logic [31:0] x_op1_val = '0;
    logic [31:0] x_rt_val = '0;
    logic [5:0]  x_wbr = '0;
    logic [31:0] x_res = '0;
    logic        x_restart = 1'b0;
    logic [31:0] x_restart_pc = '0;
    logic [31:0] dmem_addr;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wbe;
    logic        dmem_busy = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_rdata_valid = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [5:0]  m_wbr;
    logic [31:0] m_res;
    logic        m_stall;
    logic        m_restart;
    logic [31:0] m_restart_pc;

    stage_m #(.debug(1)) dut (
        .clock(clock), .reset(reset),
        .x_valid(x_valid), .x_instr(x_instr), .x_pc(x_pc), .x_opcode(x_opcode),
        .x_op1_val(x_op1_val), .x_rt_val(x_rt_val), .x_wbr(x_wbr), .x_res(x_res),
        .x_restart(x_restart), .x_restart_pc(x_restart_pc),
        .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_wdata(dmem_wdata), .dmem_wbe(dmem_wbe),
        .dmem_busy(dmem_busy), .dmem_rdata(dmem_rdata), .dmem_rdata_valid(dmem_rdata_valid),
        .m_valid(m_valid), .m_pc(m_pc), .m_wbr(m_wbr), .m_res(m_res), .m_stall(m_stall),
        .m_restart(m_restart), .m_restart_pc(m_restart_pc)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [int unsigned];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a[7:0] * 8'd37) ^ 8'h5A;
    endfunction

    function automatic int size_of(input logic [5:0] op);
        case (op)
            LB, LBU, SB: return 1;
            LH, LHU, SH: return 2;
            LW, SW:      return 4;
            default:     return 0;
        endcase
    endfunction

    task automatic do_pass(input logic [5:0] op, input logic [31:0] res, input logic [5:0] wbr,
                           input logic [31:0] pc, input logic v, input logic rs, input logic [31:0] rspc);
        x_valid = v; x_opcode = op; x_res = res; x_wbr = wbr; x_pc = pc;
        x_restart = rs; x_restart_pc = rspc;
        x_op1_val = $urandom; x_instr = $urandom; x_rt_val = $urandom;
        dmem_busy = 1'($urandom_range(0, 1));
        #1;
        check("pass_rd", dmem_rd, 0);
        check("pass_wr", dmem_wr, 0);
        check("pass_stall", m_stall, 0);
        tick;
        check("pass_valid", m_valid, v);
        if (v) begin
            check("pass_res", m_res, res);
            check("pass_wbr", m_wbr, wbr);
            check("pass_pc", m_pc, pc);
        end
        check("pass_restart", m_restart, rs);
        if (rs) check("pass_restart_pc", m_restart_pc, rspc);
        x_valid = 1'b0; x_restart = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic do_mem(input logic [5:0] op, input logic [31:0] base, input logic [15:0] off,
                          input logic [31:0] rt, input int busy, input int lat,
                          input logic [5:0] wbr, input logic [31:0] pc,
                          output logic [31:0] got_addr, output logic [3:0] got_wbe,
                          output logic [31:0] got_wdata, output logic [31:0] got_res);
        logic [31:0] ea, exp_val, exp_wd, mask, wa;
        logic [3:0]  exp_wbe;
        logic        ld;
        int          sz, lane;
        ea = base + {{16{off[15]}}, off};
        sz = size_of(op);
        ld = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
        got_addr = '0; got_wbe = '0; got_wdata = '0; got_res = '0;
        x_valid = 1'b1; x_opcode = op; x_op1_val = base; x_instr = {op, 10'h0, off};
        x_rt_val = rt; x_wbr = wbr; x_pc = pc; x_res = $urandom; x_restart = 1'b0;
        dmem_rdata_valid = 1'b0;
        if ((int'(ea[1:0]) % sz) != 0) begin
            dmem_busy = 1'($urandom_range(0, 1));
            #1;
            check("mis_rd", dmem_rd, 0);
            check("mis_wr", dmem_wr, 0);
            check("mis_stall", m_stall, 0);
            tick;
            x_valid = 1'b0; dmem_busy = 1'b0;
            check("mis_valid", m_valid, 0);
            check("mis_restart", m_restart, 1);
            check("mis_restart_pc", m_restart_pc, 32'hBFC0_0380);
            return;
        end
        exp_wbe = '0; exp_wd = '0; exp_val = '0; mask = '0;
        for (int k = 0; k < sz; k++) begin
            lane = int'(ea[1:0]) + k;
            exp_wbe[3 - lane] = 1'b1;
            mask[31 - 8 * lane -: 8] = 8'hFF;
            exp_wd[31 - 8 * lane -: 8] = 8'(rt >> (8 * (sz - 1 - k)));
            exp_val = (exp_val << 8) | {24'h0, mem_byte(ea + k)};
        end
        if (op == LB && exp_val[7]) exp_val = exp_val | 32'hFFFF_FF00;
        if (op == LH && exp_val[15]) exp_val = exp_val | 32'hFFFF_0000;
        for (int i = 0; i <= busy; i++) begin
            dmem_busy = (i < busy);
            #1;
            check("rd", dmem_rd, ld);
            check("wr", dmem_wr, !ld);
            check("addr", dmem_addr, {ea[31:2], 2'b00});
            check("stall_req", m_stall, i < busy);
            if (i > 0) check("valid_req", m_valid, 0);
            if (!ld) begin
                check("wbe", dmem_wbe, exp_wbe);
                check("wdata", dmem_wdata & mask, exp_wd & mask);
            end
            if (i == 0) begin
                got_addr = dmem_addr; got_wbe = dmem_wbe; got_wdata = dmem_wdata;
            end
            tick;
        end
        if (!ld) begin
            check("st_valid", m_valid, 1);
            check("st_wbr", m_wbr, 0);
            check("st_pc", m_pc, pc);
            x_valid = 1'b0; dmem_busy = 1'b0;
            for (int k = 0; k < sz; k++) mem[ea + k] = 8'(rt >> (8 * (sz - 1 - k)));
            return;
        end
        x_valid = 1'b0; dmem_busy = 1'b0;
        for (int j = 0; j < lat; j++) begin
            #1;
            check("wait_stall", m_stall, 1);
            check("wait_valid", m_valid, 0);
            check("wait_rd", dmem_rd, 0);
            tick;
        end
        wa = {ea[31:2], 2'b00};
        dmem_rdata = {mem_byte(wa), mem_byte(wa + 1), mem_byte(wa + 2), mem_byte(wa + 3)};
        dmem_rdata_valid = 1'b1;
        #1;
        check("resp_stall", m_stall, 1);
        tick;
        dmem_rdata_valid = 1'b0;
        dmem_rdata = $urandom;
        check("ld_valid", m_valid, 1);
        check("ld_res", m_res, exp_val);
        check("ld_wbr", m_wbr, wbr);
        check("ld_pc", m_pc, pc);
        got_res = m_res;
    endtask

    initial begin
        logic [31:0] ga, gd, gr;
        logic [3:0]  gw;
        logic [5:0]  ops [9];
        logic [5:0]  op;
        logic [15:0] off;
        int          o;
        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, ADDU};

        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_stall", m_stall, 0);
        check("rst_rd", dmem_rd, 0);
        check("rst_restart", m_restart, 0);
        reset = 1'b0;
        tick;

        do_pass(ADDU, 32'h1234_5678, 6'd5, 32'h0040_0000, 1'b1, 1'b0, '0);
        do_pass(LW, 32'hDEAD_BEEF, 6'd7, 32'h0040_0004, 1'b0, 1'b0, '0);
        do_pass(ADDU, 32'hCAFE_0001, 6'd9, 32'h0040_0008, 1'b1, 1'b1, 32'h8000_0180);

        mem[32'h1000] = 8'h11; mem[32'h1001] = 8'h22; mem[32'h1002] = 8'h33; mem[32'h1003] = 8'hF0;
        do_mem(LB, 32'h1000, 16'h0003, '0, 0, 0, 6'd3, 32'h0040_0010, ga, gw, gd, gr);
        check("lb_const", gr, 32'hFFFF_FFF0);
        do_mem(LBU, 32'h1000, 16'h0003, '0, 0, 0, 6'd4, 32'h0040_0014, ga, gw, gd, gr);
        check("lbu_const", gr, 32'h0000_00F0);

        do_mem(SH, 32'h1000, 16'h0002, 32'h0000_BEEF, 3, 0, 6'd0, 32'h0040_0018, ga, gw, gd, gr);
        check("sh_addr", ga, 32'h0000_1000);
        check("sh_wbe", gw, 4'b0011);
        check("sh_wdata", gd, 32'hBEEF_BEEF);
        do_mem(LH, 32'h1000, 16'h0002, '0, 1, 2, 6'd8, 32'h0040_001C, ga, gw, gd, gr);
        check("lh_const", gr, 32'hFFFF_BEEF);
        do_mem(SB, 32'h1000, 16'h0001, 32'h0000_00A5, 0, 0, 6'd0, 32'h0040_0020, ga, gw, gd, gr);
        check("sb_wbe", gw, 4'b0100);
        check("sb_wdata", gd, 32'hA5A5_A5A5);

        do_mem(LW, 32'h1000, 16'h0001, '0, 0, 0, 6'd2, 32'h0040_0024, ga, gw, gd, gr);
        do_mem(LW, 32'hFFFF_FFFC, 16'h0004, '0, 0, 1, 6'd2, 32'h0040_0028, ga, gw, gd, gr);
        check("wrap_addr", ga, 32'h0000_0000);

        x_valid = 1'b1; x_opcode = LB; x_op1_val = 32'h1000; x_instr = {LB, 26'h3};
        dmem_busy = 1'b0;
        #1;
        tick;
        x_valid = 1'b0;
        #1;
        check("wait_before_rst", m_stall, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_stall", m_stall, 0);
        check("rst_mid_rd", dmem_rd, 0);
        check("rst_mid_wr", dmem_wr, 0);
        check("rst_mid_wbe", dmem_wbe, 0);
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_restart", m_restart, 0);
        tick;
        reset = 1'b0;
        tick;
        dmem_rdata = 32'h7777_7777;
        dmem_rdata_valid = 1'b1;
        #1;
        check("late_resp_stall", m_stall, 0);
        tick;
        dmem_rdata_valid = 1'b0;
        check("late_resp_valid", m_valid, 0);
        tick;
        check("late_resp_valid2", m_valid, 0);
        do_pass(ADDU, 32'h0BAD_F00D, 6'd1, 32'h0040_0030, 1'b1, 1'b0, '0);

        for (int n = 0; n < 80; n++) begin
            op = ops[$urandom_range(0, 8)];
            o = int'($urandom_range(0, 16)) - 8;
            off = o[15:0];
            if (op == ADDU)
                do_pass(op, $urandom, 6'($urandom_range(1, 63)), $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom);
            else
                do_mem(op, 32'h1000 + $urandom_range(0, 31), off, $urandom, $urandom_range(0, 2),
                       $urandom_range(0, 2), 6'($urandom_range(1, 63)), $urandom, ga, gw, gd, gr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
